// File: rtl/temporal_mux_sequencer.sv
// Temporal mux sequencer: takes one request (select time plus one edge time per data input),
// holds the temporal mux in gamma reset for GRST_CYCLES, then plays a RUN phase of
// GAMMA_CYCLE_WIDTH cycles. During RUN it raises each edge-encoded line once its time is
// reached and records the first cycle in which y is sampled high. The result is then offered
// on a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_sel_time          edge time of select_line
//   req_in_times          edge time of input i in bits [i*TW +: TW]
//   grst                  gamma reset to the temporal mux (high in IDLE and GRST)
//   mux_inputs            edge-encoded mux data inputs
//   select_line           edge-encoded mux select
//   y                     temporal mux output, sampled at the end of each RUN cycle
//   res_valid/res_ready   result handshake (valid only in DONE)
//   res_time, res_hit     first RUN cycle with y high; GAMMA_CYCLE_WIDTH and 0 on a miss
module temporal_mux_sequencer #(
  parameter int unsigned NUM_INPUTS        = 4,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned GRST_CYCLES       = 2,
  localparam int unsigned TW               = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TW-1:0]            req_sel_time,
  input  logic [NUM_INPUTS*TW-1:0] req_in_times,
  output logic                     grst,
  output logic [NUM_INPUTS-1:0]    mux_inputs,
  output logic                     select_line,
  input  logic                     y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TW-1:0]            res_time,
  output logic                     res_hit
);

  // One counter serves both GRST and RUN, so it must be wide enough for either.
  localparam int unsigned GrstW = $clog2(GRST_CYCLES + 1);
  localparam int unsigned CntW  = (TW > GrstW) ? TW : GrstW;

  localparam logic [CntW-1:0] GrstLast  = CntW'(GRST_CYCLES - 1);
  localparam logic [CntW-1:0] RunLast   = CntW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0]   NeverTime = TW'(GAMMA_CYCLE_WIDTH);

  typedef enum logic [1:0] {StIdle, StGrst, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [TW-1:0]            sel_time_q, sel_time_d;
  logic [NUM_INPUTS*TW-1:0] in_times_q, in_times_d;
  logic                     select_q, select_d;
  logic [NUM_INPUTS-1:0]    mux_q, mux_d;
  logic                     hit_q, hit_d;
  logic [TW-1:0]            time_q, time_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      sel_time_q <= '0;
      in_times_q <= '0;
      select_q   <= 1'b0;
      mux_q      <= '0;
      hit_q      <= 1'b0;
      time_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sel_time_q <= sel_time_d;
      in_times_q <= in_times_d;
      select_q   <= select_d;
      mux_q      <= mux_d;
      hit_q      <= hit_d;
      time_q     <= time_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sel_time_d = sel_time_q;
    in_times_d = in_times_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d    = StGrst;
          count_d    = '0;
          sel_time_d = req_sel_time;
          in_times_d = req_in_times;
        end
      end
      StGrst: begin
        if (count_q == GrstLast) begin
          state_d = StRun;
          count_d = '0;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StRun: begin
        // Fixed length: y never shortens the RUN phase.
        if (count_q == RunLast) begin
          state_d = StDone;
          count_d = '0;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: registered edge lines are computed for the cycle being entered.
  always_comb begin
    select_d = 1'b0;
    mux_d    = '0;
    hit_d    = hit_q;
    time_d   = time_q;

    unique case (state_d)
      StRun: begin
        // OR with the current value keeps every line a single rising edge per gamma cycle.
        select_d = select_q | (CntW'(sel_time_q) <= count_d);
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
          mux_d[i] = mux_q[i] | (CntW'(in_times_q[i*TW +: TW]) <= count_d);
        end
      end
      StDone: begin
        select_d = select_q;
        mux_d    = mux_q;
      end
      default: ;
    endcase

    if (state_q == StRun && !hit_q) begin
      if (y) begin
        hit_d  = 1'b1;
        time_d = TW'(count_q);
      end else if (count_q == RunLast) begin
        time_d = NeverTime;
      end
    end

    if (state_q == StIdle && req_valid) begin
      hit_d  = 1'b0;
      time_d = '0;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign res_valid   = (state_q == StDone);
  assign grst        = (state_q == StIdle) || (state_q == StGrst);
  assign select_line = select_q;
  assign mux_inputs  = mux_q;
  assign res_hit     = hit_q;
  assign res_time    = time_q;

endmodule

// File: tb/tb_temporal_mux_sequencer.sv
// Bench for temporal_mux_sequencer: directed scenarios with literal expectations, then a
// randomized phase. A reference model tracks elapsed cycles since accept and derives every
// output from that count; a negedge process compares the DUT against it every cycle.
module tb_temporal_mux_sequencer;

  localparam int NUM  = 4;
  localparam int GW   = 16;
  localparam int GRST = 2;
  localparam int TW   = $clog2(GW) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [TW-1:0]     req_sel_time;
  logic [NUM*TW-1:0] req_in_times;
  logic              grst;
  logic [NUM-1:0]    mux_inputs;
  logic              select_line;
  logic              y;
  logic              res_valid;
  logic              res_ready;
  logic [TW-1:0]     res_time;
  logic              res_hit;

  temporal_mux_sequencer #(
    .NUM_INPUTS       (NUM),
    .GAMMA_CYCLE_WIDTH(GW),
    .GRST_CYCLES      (GRST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel_time(req_sel_time),
    .req_in_times(req_in_times),
    .grst        (grst),
    .mux_inputs  (mux_inputs),
    .select_line (select_line),
    .y           (y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_time    (res_time),
    .res_hit     (res_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: busy flag plus elapsed cycles since the accept edge.
  bit m_busy;
  int m_el;
  int m_sel;
  int m_in [NUM];
  bit m_hit;
  int m_time;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_el   <= 0;
      m_hit  <= 1'b0;
      m_time <= 0;
    end else if (!m_busy) begin
      if (req_valid === 1'b1) begin
        m_busy <= 1'b1;
        m_el   <= 0;
        m_sel  <= int'(req_sel_time);
        for (int i = 0; i < NUM; i++) m_in[i] <= int'(req_in_times[i*TW +: TW]);
        m_hit  <= 1'b0;
        m_time <= 0;
      end
    end else begin
      if (m_el >= GRST && m_el < GRST + GW && !m_hit && y === 1'b1) begin
        m_hit  <= 1'b1;
        m_time <= m_el - GRST;
      end
      if (m_el < GRST + GW) m_el <= m_el + 1;
      else if (res_ready === 1'b1) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    int             k;
    logic           e_grst, e_ready, e_valid, e_sel;
    logic [NUM-1:0] e_mux;
    e_grst  = 1'b1;
    e_ready = !m_busy;
    e_valid = 1'b0;
    e_sel   = 1'b0;
    e_mux   = '0;
    if (m_busy && m_el >= GRST) begin
      e_grst  = 1'b0;
      k       = (m_el < GRST + GW) ? m_el - GRST : GW - 1;
      e_valid = (m_el >= GRST + GW);
      e_sel   = (m_sel <= k);
      for (int i = 0; i < NUM; i++) e_mux[i] = (m_in[i] <= k);
    end
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("grst", 32'(grst), 32'(e_grst));
    check("res_valid", 32'(res_valid), 32'(e_valid));
    check("select_line", 32'(select_line), 32'(e_sel));
    check("mux_inputs", 32'(mux_inputs), 32'(e_mux));
    if (e_valid) begin
      check("res_hit", 32'(res_hit), 32'(m_hit));
      check("res_time", 32'(res_time), m_hit ? 32'(m_time) : 32'(GW));
    end
  end

  int sel_rise;
  int mux_rise [NUM];

  // Issue a request from IDLE, drive y high from RUN cycle y_k on, and return the number
  // of edges from accept to res_valid along with the RUN cycle each line first rose.
  task automatic run_txn(input int sel, input int t0, input int t1, input int t2, input int t3,
                         input int y_k, output int lat);
    req_sel_time = TW'(sel);
    req_in_times = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
    req_valid    = 1'b1;
    res_ready    = 1'b0;
    y            = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat       = 0;
    sel_rise  = -1;
    for (int i = 0; i < NUM; i++) mux_rise[i] = -1;
    while (lat < 100 && res_valid !== 1'b1) begin
      y = (lat >= GRST + y_k);
      @(posedge clk);
      #1;
      lat++;
      if (select_line === 1'b1 && sel_rise < 0) sel_rise = lat - GRST;
      for (int i = 0; i < NUM; i++)
        if (mux_inputs[i] === 1'b1 && mux_rise[i] < 0) mux_rise[i] = lat - GRST;
    end
    y = 1'b0;
  endtask

  task automatic ack_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  int lat;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_sel_time = '0;
    req_in_times = '0;
    y            = 1'b0;
    res_ready    = 1'b0;
    #1;
    check("reset_grst", 32'(grst), 32'd1);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_mux", 32'(mux_inputs), 32'd0);
    check("reset_res_time", 32'(res_time), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Basic hit
    run_txn(3, 2, 3, 5, 16, 3, lat);
    check("basic_latency", 32'(lat), 32'd18);
    check("basic_hit", 32'(res_hit), 32'd1);
    check("basic_time", 32'(res_time), 32'd3);
    check("basic_model_time", 32'(m_time), 32'd3);
    check("basic_sel_rise", 32'(sel_rise), 32'd3);
    check("basic_mux0_rise", 32'(mux_rise[0]), 32'd2);
    check("basic_mux1_rise", 32'(mux_rise[1]), 32'd3);
    check("basic_mux2_rise", 32'(mux_rise[2]), 32'd5);
    check("basic_mux3_rise", 32'(mux_rise[3]), 32'hffff_ffff);
    ack_result();
    check("basic_back_idle", 32'(req_ready), 32'd1);

    // Boundary times
    run_txn(0, 15, 0, 31, 16, 15, lat);
    check("bound_latency", 32'(lat), 32'd18);
    check("bound_sel_rise", 32'(sel_rise), 32'd0);
    check("bound_mux0_rise", 32'(mux_rise[0]), 32'd15);
    check("bound_mux1_rise", 32'(mux_rise[1]), 32'd0);
    check("bound_mux2_rise", 32'(mux_rise[2]), 32'hffff_ffff);
    check("bound_time", 32'(res_time), 32'd15);
    check("bound_hit", 32'(res_hit), 32'd1);
    ack_result();

    // Backpressure with y toggling and a competing request
    run_txn(4, 1, 2, 3, 4, 2, lat);
    req_valid    = 1'b1;
    req_sel_time = '0;
    req_in_times = '0;
    for (int c = 0; c < 5; c++) begin
      y = ~y;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_time", 32'(res_time), 32'd2);
      check("bp_hit", 32'(res_hit), 32'd1);
      check("bp_sel", 32'(select_line), 32'd1);
      check("bp_mux", 32'(mux_inputs), 32'hf);
      check("bp_grst", 32'(grst), 32'd0);
    end
    y = 1'b0;
    ack_result();
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(res_valid), 32'd0);

    // Back-to-back request that misses
    run_txn(0, 0, 0, 0, 0, 1000, lat);
    check("miss_latency", 32'(lat), 32'd18);
    check("miss_hit", 32'(res_hit), 32'd0);
    check("miss_time", 32'(res_time), 32'd16);
    check("miss_sel_rise", 32'(sel_rise), 32'd0);
    ack_result();

    // Reset in RUN cycle 7
    req_sel_time = TW'(3);
    req_in_times = {TW'(1), TW'(2), TW'(9), TW'(4)};
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (GRST + 7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    req_valid = 1'b1;
    #1;
    check("rst_grst", 32'(grst), 32'd1);
    check("rst_sel", 32'(select_line), 32'd0);
    check("rst_mux", 32'(mux_inputs), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(req_ready), 32'd1);
    run_txn(5, 5, 5, 5, 5, 6, lat);
    check("rst_new_latency", 32'(lat), 32'd18);
    check("rst_new_time", 32'(res_time), 32'd6);
    ack_result();

    // Randomized traffic, including occasional asynchronous resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      req_valid    = ($urandom % 3) == 0;
      req_sel_time = TW'($urandom_range(0, 20));
      for (int i = 0; i < NUM; i++) req_in_times[i*TW +: TW] = TW'($urandom_range(0, 20));
      y         = ($urandom % 6) == 0;
      res_ready = ($urandom % 3) != 0;
      if (($urandom % 300) == 0) begin
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
